// File: rtl/word_serializer.sv
// Word-to-byte serializer: takes one width-bit word per handshake and emits it
// as nbytes 8-bit beats, flagging the final beat and counting completed words.
module word_serializer #(
  parameter int width     = 32,
  parameter bit msb_first = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [width-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic [15:0]      word_count
);

  localparam int NBYTES = width / 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  typedef enum logic {EMPTY, SHIFT} state_t;

  state_t             state_p0, state_nxt;
  logic [width-1:0]   hold_p0, hold_nxt;
  logic [IDX_W-1:0]   idx_p0, idx_nxt;
  logic [15:0]        cnt_p0, cnt_nxt;
  logic               word_acc, byte_acc;

  function automatic logic [7:0] sel_byte(input logic [width-1:0] w,
                                          input logic [IDX_W-1:0] i);
    int k;
    k = msb_first ? (NBYTES - 1 - int'(i)) : int'(i);
    return w[8*k +: 8];
  endfunction

  always_comb begin
    state_nxt = state_p0;
    hold_nxt  = hold_p0;
    idx_nxt   = idx_p0;
    cnt_nxt   = cnt_p0;

    out_valid = (state_p0 == SHIFT);
    out_last  = out_valid && (idx_p0 == LAST_IDX);
    // Refill is allowed only as the last byte leaves, keeping the stream bubble-free.
    in_ready  = (state_p0 == EMPTY) || (out_last && out_ready);
    word_acc  = in_valid && in_ready;
    byte_acc  = out_valid && out_ready;

    unique case (state_p0)
      EMPTY: begin
        if (word_acc) begin
          hold_nxt  = in_data;
          idx_nxt   = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (byte_acc) begin
          if (out_last) begin
            cnt_nxt = cnt_p0 + 16'd1;
            if (word_acc) begin
              hold_nxt = in_data;
              idx_nxt  = '0;
            end else begin
              state_nxt = EMPTY;
            end
          end else begin
            idx_nxt = idx_p0 + 1'b1;
          end
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Register stage: held word, byte index, state and word counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_p0 <= EMPTY;
      hold_p0  <= '0;
      idx_p0   <= '0;
      cnt_p0   <= '0;
    end else begin
      state_p0 <= state_nxt;
      hold_p0  <= hold_nxt;
      idx_p0   <= idx_nxt;
      cnt_p0   <= cnt_nxt;
    end
  end

  assign out_data   = sel_byte(hold_p0, idx_p0);
  assign word_count = cnt_p0;

endmodule

// File: tb/tb_word_serializer.sv
// Directed bench for word_serializer: three instances (32-bit LSB-first,
// 32-bit MSB-first, 8-bit) driven on the falling edge and checked #1 later.
module tb_word_serializer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] a_in_data, b_in_data;
  logic [7:0]  c_in_data;
  logic        a_in_valid, b_in_valid, c_in_valid;
  logic        a_in_ready, b_in_ready, c_in_ready;
  logic [7:0]  a_out_data, b_out_data, c_out_data;
  logic        a_out_valid, b_out_valid, c_out_valid;
  logic        a_out_ready, b_out_ready, c_out_ready;
  logic        a_out_last, b_out_last, c_out_last;
  logic [15:0] a_count, b_count, c_count;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] e [8];

  word_serializer #(.width(32), .msb_first(1'b0)) u_a (
    .clock(clk), .reset(rst), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .out_data(a_out_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_last(a_out_last), .word_count(a_count));

  word_serializer #(.width(32), .msb_first(1'b1)) u_b (
    .clock(clk), .reset(rst), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .out_data(b_out_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_last(b_out_last), .word_count(b_count));

  word_serializer #(.width(8), .msb_first(1'b0)) u_c (
    .clock(clk), .reset(rst), .in_data(c_in_data), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .out_data(c_out_data), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_last(c_out_last), .word_count(c_count));

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if ({a_in_ready, a_out_valid, a_out_last, a_out_data, a_count} !== {3'b100, 8'h00, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset_a got rdy=%b vld=%b last=%b data=%h cnt=%h want rdy=1 vld=0 last=0 data=00 cnt=0000",
               a_in_ready, a_out_valid, a_out_last, a_out_data, a_count);
    end
    n_checks++;
    if ({b_in_ready, b_out_valid, b_out_last, b_out_data, b_count} !== {3'b100, 8'h00, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset_b got rdy=%b vld=%b last=%b data=%h cnt=%h want 1 0 0 00 0000",
               b_in_ready, b_out_valid, b_out_last, b_out_data, b_count);
    end
    n_checks++;
    if ({c_in_ready, c_out_valid, c_out_last, c_out_data, c_count} !== {3'b100, 8'h00, 16'h0000}) begin
      n_fail++;
      $display("FAIL reset_c got rdy=%b vld=%b last=%b data=%h cnt=%h want 1 0 0 00 0000",
               c_in_ready, c_out_valid, c_out_last, c_out_data, c_count);
    end
  endtask

  task automatic test_lsb_first();
    e[0] = 8'h11; e[1] = 8'h22; e[2] = 8'h33; e[3] = 8'h44;
    @(negedge clk);
    a_in_data = 32'h44332211; a_in_valid = 1'b1; a_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a_in_valid = 1'b0;
      a_in_data  = 32'hDEADBEEF;
      #1;
      n_checks++;
      if ({a_out_valid, a_out_last, a_out_data} !== {1'b1, (i == 3), e[i]}) begin
        n_fail++;
        $display("FAIL lsb_byte%0d got vld=%b last=%b data=%h want vld=1 last=%b data=%h",
                 i, a_out_valid, a_out_last, a_out_data, (i == 3), e[i]);
      end
    end
    @(negedge clk);
    #1;
    n_checks++;
    if ({a_out_valid, a_in_ready, a_count} !== {2'b01, 16'd1}) begin
      n_fail++;
      $display("FAIL lsb_done got vld=%b rdy=%b cnt=%0d want vld=0 rdy=1 cnt=1",
               a_out_valid, a_in_ready, a_count);
    end
  endtask

  task automatic test_msb_first();
    e[0] = 8'h44; e[1] = 8'h33; e[2] = 8'h22; e[3] = 8'h11;
    @(negedge clk);
    b_in_data = 32'h44332211; b_in_valid = 1'b1; b_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      b_in_valid = 1'b0;
      #1;
      n_checks++;
      if ({b_out_valid, b_out_last, b_out_data} !== {1'b1, (i == 3), e[i]}) begin
        n_fail++;
        $display("FAIL msb_byte%0d got vld=%b last=%b data=%h want vld=1 last=%b data=%h",
                 i, b_out_valid, b_out_last, b_out_data, (i == 3), e[i]);
      end
    end
    @(negedge clk);
    #1;
    n_checks++;
    if ({b_out_valid, b_count} !== {1'b0, 16'd1}) begin
      n_fail++;
      $display("FAIL msb_done got vld=%b cnt=%0d want vld=0 cnt=1", b_out_valid, b_count);
    end
  endtask

  task automatic test_back_to_back();
    e[0] = 8'h11; e[1] = 8'h22; e[2] = 8'h33; e[3] = 8'h44;
    e[4] = 8'h55; e[5] = 8'h66; e[6] = 8'h77; e[7] = 8'h88;
    test_reset();
    @(negedge clk);
    a_in_data = 32'h44332211; a_in_valid = 1'b1; a_out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 0) a_in_data = 32'h88776655;
      if (i == 4) a_in_valid = 1'b0;
      #1;
      n_checks++;
      if ({a_out_valid, a_out_last, a_in_ready, a_out_data} !==
          {1'b1, (i % 4 == 3), (i % 4 == 3), e[i]}) begin
        n_fail++;
        $display("FAIL b2b_byte%0d got vld=%b last=%b rdy=%b data=%h want vld=1 last=%b rdy=%b data=%h",
                 i, a_out_valid, a_out_last, a_in_ready, a_out_data,
                 (i % 4 == 3), (i % 4 == 3), e[i]);
      end
    end
    @(negedge clk);
    #1;
    n_checks++;
    if ({a_out_valid, a_count} !== {1'b0, 16'd2}) begin
      n_fail++;
      $display("FAIL b2b_done got vld=%b cnt=%0d want vld=0 cnt=2", a_out_valid, a_count);
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    a_in_data = 32'h44332211; a_in_valid = 1'b1; a_out_ready = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    #1;
    n_checks++;
    if ({a_out_valid, a_out_data} !== {1'b1, 8'h11}) begin
      n_fail++;
      $display("FAIL bp_first got vld=%b data=%h want vld=1 data=11", a_out_valid, a_out_data);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      a_out_ready = 1'b0;
      a_in_valid  = 1'b1;
      a_in_data   = 32'hCAFEF00D;
      #1;
      n_checks++;
      if ({a_out_valid, a_out_last, a_in_ready, a_out_data} !== {3'b100, 8'h22}) begin
        n_fail++;
        $display("FAIL bp_stall%0d got vld=%b last=%b rdy=%b data=%h want vld=1 last=0 rdy=0 data=22",
                 k, a_out_valid, a_out_last, a_in_ready, a_out_data);
      end
    end
    @(negedge clk);
    a_out_ready = 1'b1;
    a_in_valid  = 1'b0;
    #1;
    n_checks++;
    if ({a_out_valid, a_out_data} !== {1'b1, 8'h22}) begin
      n_fail++;
      $display("FAIL bp_release got vld=%b data=%h want vld=1 data=22", a_out_valid, a_out_data);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if ({a_out_valid, a_out_last, a_out_data} !== {2'b10, 8'h33}) begin
      n_fail++;
      $display("FAIL bp_resume got vld=%b last=%b data=%h want vld=1 last=0 data=33",
               a_out_valid, a_out_last, a_out_data);
    end
  endtask

  task automatic test_reset_mid_word();
    rst = 1'b1;
    a_in_valid = 1'b1;
    a_in_data  = 32'h0BADC0DE;
    @(negedge clk);
    rst = 1'b0;
    a_in_valid = 1'b0;
    #1;
    n_checks++;
    if ({a_out_valid, a_in_ready, a_count} !== {2'b01, 16'd0}) begin
      n_fail++;
      $display("FAIL rst_mid got vld=%b rdy=%b cnt=%0d want vld=0 rdy=1 cnt=0",
               a_out_valid, a_in_ready, a_count);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (a_out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_no_resume%0d got vld=%b data=%h want vld=0", k, a_out_valid, a_out_data);
      end
    end
  endtask

  task automatic test_width8();
    @(negedge clk);
    c_in_data = 8'hA5; c_in_valid = 1'b1; c_out_ready = 1'b1;
    @(negedge clk);
    c_in_data = 8'h5A;
    #1;
    n_checks++;
    if ({c_out_valid, c_out_last, c_in_ready, c_out_data} !== {3'b111, 8'hA5}) begin
      n_fail++;
      $display("FAIL w8_first got vld=%b last=%b rdy=%b data=%h want 1 1 1 a5",
               c_out_valid, c_out_last, c_in_ready, c_out_data);
    end
    @(negedge clk);
    c_in_valid = 1'b0;
    #1;
    n_checks++;
    if ({c_out_valid, c_out_last, c_out_data} !== {2'b11, 8'h5A}) begin
      n_fail++;
      $display("FAIL w8_second got vld=%b last=%b data=%h want 1 1 5a",
               c_out_valid, c_out_last, c_out_data);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if ({c_out_valid, c_count} !== {1'b0, 16'd2}) begin
      n_fail++;
      $display("FAIL w8_done got vld=%b cnt=%0d want vld=0 cnt=2", c_out_valid, c_count);
    end
  endtask

  task automatic test_count_wrap();
    // Count is 2 here; 65534 streaming edges leave 0xFFFF done plus one word held.
    @(negedge clk);
    c_in_data = 8'h3C; c_in_valid = 1'b1; c_out_ready = 1'b1;
    repeat (65534) @(negedge clk);
    c_in_valid = 1'b0;
    #1;
    n_checks++;
    if ({c_out_valid, c_out_last, c_count} !== {2'b11, 16'hFFFF}) begin
      n_fail++;
      $display("FAIL wrap_pre got vld=%b last=%b cnt=%h want vld=1 last=1 cnt=ffff",
               c_out_valid, c_out_last, c_count);
    end
    @(negedge clk);
    #1;
    n_checks++;
    if ({c_out_valid, c_count} !== {1'b0, 16'h0000}) begin
      n_fail++;
      $display("FAIL wrap_post got vld=%b cnt=%h want vld=0 cnt=0000", c_out_valid, c_count);
    end
  endtask

  initial begin
    rst = 1'b1;
    a_in_data = '0; a_in_valid = 1'b0; a_out_ready = 1'b1;
    b_in_data = '0; b_in_valid = 1'b0; b_out_ready = 1'b1;
    c_in_data = '0; c_in_valid = 1'b0; c_out_ready = 1'b1;
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
    test_width8();
    test_count_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
